// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - opcode constants for the TD4 core
// Purpose: shared opcode field width and the 4-bit opcode encodings.
// Ports: none (package).
package td4_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD_A  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV_AB = 4'b0001;  // A <= B
  localparam logic [OPC_W-1:0] OP_IN_A   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_MOV_A  = 4'b0011;  // A <= Im
  localparam logic [OPC_W-1:0] OP_MOV_BA = 4'b0100;  // B <= A
  localparam logic [OPC_W-1:0] OP_ADD_B  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_IN_B   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MOV_B  = 4'b0111;  // B <= Im
  localparam logic [OPC_W-1:0] OP_OUT_B  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_OUT_IM = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JNC    = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'b1111;

endpackage

// File: rtl/td4_alu.sv
// rtl/td4_alu.sv - combinational adder with A/B operand select
// Purpose: adds the immediate to register A or B, returning sum and carry-out.
// Ports: i_reg_a, i_reg_b - register operands; i_sel_b - 1 selects B;
//        i_imm - immediate addend; o_sum - low DATA_W bits; o_carry - carry-out.
module td4_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_reg_a,
  input  logic [DATA_W-1:0] i_reg_b,
  input  logic              i_sel_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  logic [DATA_W-1:0] w_opnd;

  assign w_opnd = i_sel_b ? i_reg_b : i_reg_a;
  assign {o_carry, o_sum} = {1'b0, w_opnd} + {1'b0, i_imm};

endmodule

// File: rtl/td4_core.sv
// rtl/td4_core.sv - single-cycle TD4 processor core
// Purpose: fetches instr_data at instr_addr and executes one instruction per
//          valid cycle; holds PC, A, B, carry and the output register.
// Ports: clk, rst (sync, active-high); instr_data/instr_valid - instruction
//        word and its qualifier; in_port - external input; instr_addr - PC;
//        out_port/out_strobe - output register and its one-cycle write pulse;
//        reg_a, reg_b, carry - architectural state.
module td4_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W+3:0]   instr_data,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   in_port,
  output logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   out_port,
  output logic                out_strobe,
  output logic [DATA_W-1:0]   reg_a,
  output logic [DATA_W-1:0]   reg_b,
  output logic                carry
);

  import td4_pkg::*;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_strobe;
  logic              r_carry;

  logic [OPC_W-1:0]  w_opcode;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_target;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_sel_b;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_a_nxt;
  logic [DATA_W-1:0] w_b_nxt;
  logic [DATA_W-1:0] w_out_nxt;
  logic              w_strobe_nxt;
  logic              w_carry_nxt;

  assign w_opcode = instr_data[DATA_W+OPC_W-1:DATA_W];
  assign w_imm    = instr_data[DATA_W-1:0];
  assign w_sel_b  = (w_opcode == OP_ADD_B);

  // Jump target: immediate zero-extended or truncated to the PC width.
  generate
    if (ADDR_W > DATA_W) begin : g_tgt_ext
      assign w_target = {{(ADDR_W-DATA_W){1'b0}}, w_imm};
    end else begin : g_tgt_trunc
      assign w_target = w_imm[ADDR_W-1:0];
    end
  endgenerate

  td4_alu #(.DATA_W(DATA_W)) u_alu (
    .i_reg_a (r_a),
    .i_reg_b (r_b),
    .i_sel_b (w_sel_b),
    .i_imm   (w_imm),
    .o_sum   (w_sum),
    .o_carry (w_cout)
  );

  // Everything not ADD clears carry, so carry defaults to 0 here.
  always_comb begin
    w_pc_nxt     = r_pc + ADDR_W'(1);
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_out_nxt    = r_out;
    w_strobe_nxt = 1'b0;
    w_carry_nxt  = 1'b0;
    case (w_opcode)
      OP_ADD_A:  begin w_a_nxt = w_sum; w_carry_nxt = w_cout; end
      OP_ADD_B:  begin w_b_nxt = w_sum; w_carry_nxt = w_cout; end
      OP_MOV_A:  w_a_nxt = w_imm;
      OP_MOV_B:  w_b_nxt = w_imm;
      OP_MOV_AB: w_a_nxt = r_b;
      OP_MOV_BA: w_b_nxt = r_a;
      OP_IN_A:   w_a_nxt = in_port;
      OP_IN_B:   w_b_nxt = in_port;
      OP_OUT_B:  begin w_out_nxt = r_b;   w_strobe_nxt = 1'b1; end
      OP_OUT_IM: begin w_out_nxt = w_imm; w_strobe_nxt = 1'b1; end
      OP_JMP:    w_pc_nxt = w_target;
      // Tests the carry held before this instruction.
      OP_JNC:    if (!r_carry) w_pc_nxt = w_target;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_out    <= '0;
      r_strobe <= 1'b0;
      r_carry  <= 1'b0;
    end else if (instr_valid) begin
      r_pc     <= w_pc_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_out    <= w_out_nxt;
      r_strobe <= w_strobe_nxt;
      r_carry  <= w_carry_nxt;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign instr_addr = r_pc;
  assign out_port   = r_out;
  assign out_strobe = r_strobe;
  assign reg_a      = r_a;
  assign reg_b      = r_b;
  assign carry      = r_carry;

endmodule

// File: tb/tb_td4_core.sv
// tb/tb_td4_core.sv - self-checking bench for td4_core (4/4 and 8/6 builds)
module tb_td4_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Unit 0: DATA_W=4, ADDR_W=4
  logic        rst4 = 1'b1, valid4 = 1'b0;
  logic [7:0]  data4 = '0;
  logic [3:0]  in4 = '0;
  logic [3:0]  addr4, out4, a4, b4;
  logic        stb4, c4;

  // Unit 1: DATA_W=8, ADDR_W=6
  logic        rst8 = 1'b1, valid8 = 1'b0;
  logic [11:0] data8 = '0;
  logic [7:0]  in8 = '0;
  logic [5:0]  addr8;
  logic [7:0]  out8, a8, b8;
  logic        stb8, c8;

  td4_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst4), .instr_data(data4), .instr_valid(valid4),
    .in_port(in4), .instr_addr(addr4), .out_port(out4), .out_strobe(stb4),
    .reg_a(a4), .reg_b(b4), .carry(c4)
  );

  td4_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk(clk), .rst(rst8), .instr_data(data8), .instr_valid(valid8),
    .in_port(in8), .instr_addr(addr8), .out_port(out8), .out_strobe(stb8),
    .reg_a(a8), .reg_b(b8), .carry(c8)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  int DW [2] = '{4, 8};
  int AW [2] = '{4, 6};
  int m_pc [2], m_a [2], m_b [2], m_c [2], m_out [2], m_stb [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: what one edge does to the machine state.
  task automatic model_step(input int u, input bit r, input bit v, input int word, input int inp);
    int dm, am, op, imm, s, npc, nc;
    dm  = (1 << DW[u]) - 1;
    am  = (1 << AW[u]) - 1;
    op  = (word >> DW[u]) & 15;
    imm = word & dm;
    if (r) begin
      m_pc[u] = 0; m_a[u] = 0; m_b[u] = 0; m_c[u] = 0; m_out[u] = 0; m_stb[u] = 0;
    end else if (!v) begin
      m_stb[u] = 0;
    end else begin
      npc = (m_pc[u] + 1) & am;
      nc  = 0;
      m_stb[u] = 0;
      case (op)
        0:  begin s = m_a[u] + imm; m_a[u] = s & dm; nc = s >> DW[u]; end
        5:  begin s = m_b[u] + imm; m_b[u] = s & dm; nc = s >> DW[u]; end
        3:  m_a[u] = imm;
        7:  m_b[u] = imm;
        1:  m_a[u] = m_b[u];
        4:  m_b[u] = m_a[u];
        2:  m_a[u] = inp & dm;
        6:  m_b[u] = inp & dm;
        9:  begin m_out[u] = m_b[u]; m_stb[u] = 1; end
        11: begin m_out[u] = imm;    m_stb[u] = 1; end
        15: npc = imm & am;
        14: if (m_c[u] == 0) npc = imm & am;
        default: ;
      endcase
      m_pc[u] = npc;
      m_c[u]  = nc;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0, rst4, valid4, int'(data4), int'(in4));
      model_step(1, rst8, valid8, int'(data8), int'(in8));
    end
  end

  // Every-cycle comparison of both units against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("u0 pc",     32'(addr4), 32'(m_pc[0]));
        chk("u0 a",      32'(a4),    32'(m_a[0]));
        chk("u0 b",      32'(b4),    32'(m_b[0]));
        chk("u0 carry",  32'(c4),    32'(m_c[0]));
        chk("u0 out",    32'(out4),  32'(m_out[0]));
        chk("u0 strobe", 32'(stb4),  32'(m_stb[0]));
        chk("u1 pc",     32'(addr8), 32'(m_pc[1]));
        chk("u1 a",      32'(a8),    32'(m_a[1]));
        chk("u1 b",      32'(b8),    32'(m_b[1]));
        chk("u1 carry",  32'(c8),    32'(m_c[1]));
        chk("u1 out",    32'(out8),  32'(m_out[1]));
        chk("u1 strobe", 32'(stb8),  32'(m_stb[1]));
      end
    end
  end

  // Drive one cycle on unit u (other unit idles), then wait past the edge.
  task automatic exec(input int u, input bit r, input bit v, input int op, input int imm, input int inp);
    @(negedge clk);
    if (u == 0) begin
      rst4 = r; valid4 = v; data4 = 8'((op << 4) | (imm & 15)); in4 = 4'(inp);
      rst8 = 1'b0; valid8 = 1'b0;
    end else begin
      rst8 = r; valid8 = v; data8 = 12'((op << 8) | (imm & 255)); in8 = 8'(inp);
      rst4 = 1'b0; valid4 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("rst pc",     32'(addr4), 32'd0);
    chk("rst a",      32'(a4),    32'd0);
    chk("rst strobe", 32'(stb4),  32'd0);
    chk("rst u1 pc",  32'(addr8), 32'd0);

    // MOV A,3; ADD A,14; JNC 7 (not taken)
    exec(0, 0, 1, 4'b0011, 3, 0);
    exec(0, 0, 1, 4'b0000, 14, 0);
    chk("add a wrap",  32'(a4), 32'd1);
    chk("add a carry", 32'(c4), 32'd1);
    exec(0, 0, 1, 4'b1110, 7, 0);
    chk("jnc nt pc",    32'(addr4), 32'd3);
    chk("jnc nt carry", 32'(c4),    32'd0);

    // MOV B,5; ADD B,1; JNC 0 (taken)
    exec(0, 0, 1, 4'b0111, 5, 0);
    exec(0, 0, 1, 4'b0101, 1, 0);
    chk("add b", 32'(b4), 32'd6);
    exec(0, 0, 1, 4'b1110, 0, 0);
    chk("jnc tk pc", 32'(addr4), 32'd0);

    // IN A; MOV B,A; OUT B; NOP
    exec(0, 0, 1, 4'b0010, 0, 9);
    exec(0, 0, 1, 4'b0100, 0, 0);
    exec(0, 0, 1, 4'b1001, 0, 0);
    chk("in a",      32'(a4),   32'd9);
    chk("mov b,a",   32'(b4),   32'd9);
    chk("out b",     32'(out4), 32'd9);
    chk("strobe on", 32'(stb4), 32'd1);
    exec(0, 0, 1, 4'b1000, 0, 0);
    chk("strobe off", 32'(stb4), 32'd0);

    // Reset; JMP 15; NOP wraps to 0; NOP clears carry
    exec(0, 1, 1, 4'b0011, 5, 0);
    exec(0, 0, 1, 4'b1111, 15, 0);
    chk("jmp 15", 32'(addr4), 32'd15);
    exec(0, 0, 1, 4'b1000, 0, 0);
    chk("pc wrap", 32'(addr4), 32'd0);
    exec(0, 0, 1, 4'b0011, 1, 0);
    exec(0, 0, 1, 4'b0000, 15, 0);
    chk("carry set", 32'(c4), 32'd1);
    exec(0, 0, 1, 4'b1000, 0, 0);
    chk("nop clears carry", 32'(c4), 32'd0);

    // OUT Im 6, then 3 stall cycles, then resume at same pc
    exec(0, 0, 1, 4'b1011, 6, 0);
    for (int i = 0; i < 3; i++) begin
      exec(0, 0, 0, 4'b0011, 15, 0);
      chk("stall pc",     32'(addr4), 32'd4);
      chk("stall strobe", 32'(stb4),  32'd0);
      chk("stall out",    32'(out4),  32'd6);
    end
    exec(0, 0, 1, 4'b0111, 2, 0);
    chk("resume pc", 32'(addr4), 32'd5);
    chk("resume b",  32'(b4),    32'd2);

    // Back-to-back OUT Im
    exec(0, 0, 1, 4'b1011, 1, 0);
    chk("b2b strobe 1", 32'(stb4), 32'd1);
    exec(0, 0, 1, 4'b1011, 2, 0);
    chk("b2b strobe 2", 32'(stb4), 32'd1);
    chk("b2b out",      32'(out4), 32'd2);

    // Reset beats ADD A,15 with A=8
    exec(0, 0, 1, 4'b0011, 8, 0);
    exec(0, 1, 1, 4'b0000, 15, 0);
    chk("rst prio a",  32'(a4),    32'd0);
    chk("rst prio c",  32'(c4),    32'd0);
    chk("rst prio pc", 32'(addr4), 32'd0);
    exec(0, 0, 1, 4'b0011, 3, 0);
    chk("post rst pc", 32'(addr4), 32'd1);
    chk("post rst a",  32'(a4),    32'd3);

    // 8/6 build: MOV A,3; ADD A,254; JNC 7; JMP truncation; pc wrap at 63
    exec(1, 1, 1, 4'b0011, 1, 0);
    exec(1, 0, 1, 4'b0011, 3, 0);
    exec(1, 0, 1, 4'b0000, 254, 0);
    chk("u1 add a",  32'(a8), 32'd1);
    chk("u1 carry",  32'(c8), 32'd1);
    exec(1, 0, 1, 4'b1110, 7, 0);
    chk("u1 jnc nt", 32'(addr8), 32'd3);
    exec(1, 0, 1, 4'b1111, 8'h45, 0);
    chk("u1 jmp trunc", 32'(addr8), 32'd5);
    exec(1, 0, 1, 4'b1111, 63, 0);
    exec(1, 0, 1, 4'b1000, 0, 0);
    chk("u1 pc wrap", 32'(addr8), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
